// File: rtl/pc_target_table_pkg.sv
// Shared sizes, PC type and program-entry defaults for the jump-target table.
package pc_target_table_pkg;

  localparam int D         = 12;
  localparam int AW        = 8;
  localparam int DEPTH     = 16;
  localparam int RAS_DEPTH = 4;
  localparam int IW        = $clog2(DEPTH);

  typedef logic [D-1:0] pc_t;

  localparam int  PC_TGT_NDEF = 8;
  localparam pc_t PC_TGT_DEFAULT [PC_TGT_NDEF] = '{
    12'd0, 12'd17, 12'd30, 12'd53, 12'd75, 12'd84, 12'd87, 12'd90
  };

  // Entries past the program-entry list default to 1.
  function automatic pc_t default_entry(input int i);
    if (i < PC_TGT_NDEF) return PC_TGT_DEFAULT[i[2:0]];
    return pc_t'(1);
  endfunction

endpackage

// File: rtl/pc_target_table_if.sv
// Request/response bundle between fetch and the jump-target table.
interface pc_target_table_if;
  import pc_target_table_pkg::*;

  logic          lookup;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  pc_t           wr_target;
  logic          call;
  logic          ret;
  pc_t           link_pc;
  logic          tgt_valid;
  pc_t           target;
  logic          hit;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_overflow;

  modport master (
    output lookup, addr, wr_en, wr_idx, wr_target, call, ret, link_pc,
    input  tgt_valid, target, hit, ras_empty, ras_full, ras_overflow
  );

  modport slave (
    input  lookup, addr, wr_en, wr_idx, wr_target, call, ret, link_pc,
    output tgt_valid, target, hit, ras_empty, ras_full, ras_overflow
  );

endinterface

// File: rtl/pc_target_table_link_stack.sv
// Circular return-address stack: push, pop, or exchange-top when both are requested.
module pc_target_table_link_stack
  import pc_target_table_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  pc_t  push_data,
  output pc_t  top,
  output logic empty,
  output logic full,
  output logic overflow
);

  localparam int PW = $clog2(RAS_DEPTH);

  pc_t           stack [RAS_DEPTH];
  logic [PW-1:0] sp;
  logic [PW:0]   count;
  logic [PW-1:0] top_idx;

  assign top_idx = sp - 1'b1;
  assign top     = stack[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(RAS_DEPTH));

  // When full, sp already points at the oldest slot, so a push simply overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (push && pop && !empty) begin
      stack[top_idx] <= push_data;
    end else if (push) begin
      stack[sp] <= push_data;
      sp        <= sp + 1'b1;
      if (full) overflow <= 1'b1;
      else      count    <= count + 1'b1;
    end else if (pop && !empty) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_target_table.sv
// Programmable jump-target table plus link stack; resolves a registered target one cycle after a request.
module pc_target_table
  import pc_target_table_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  pc_target_table_if.slave  bus
);

  pc_t           tbl [DEPTH];
  pc_t           ras_top;
  logic          ras_empty_w;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          fwd;

  assign idx      = bus.addr[IW-1:0];
  assign in_range = ((bus.addr >> IW) == '0);
  assign fwd      = bus.wr_en && (bus.wr_idx == idx);
  assign bus.ras_empty = ras_empty_w;

  pc_target_table_link_stack u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.call),
    .pop       (bus.ret),
    .push_data (bus.link_pc),
    .top       (ras_top),
    .empty     (ras_empty_w),
    .full      (bus.ras_full),
    .overflow  (bus.ras_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= default_entry(i);
    end else if (bus.wr_en) begin
      tbl[bus.wr_idx] <= bus.wr_target;
    end
  end

  // Return wins over lookup; target/hit hold between requests while tgt_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tgt_valid <= 1'b0;
      bus.target    <= '0;
      bus.hit       <= 1'b0;
    end else begin
      bus.tgt_valid <= bus.ret || bus.lookup;
      if (bus.ret) begin
        bus.target <= ras_empty_w ? '0 : ras_top;
        bus.hit    <= !ras_empty_w;
      end else if (bus.lookup) begin
        if (in_range) begin
          bus.target <= fwd ? bus.wr_target : tbl[idx];
          bus.hit    <= 1'b1;
        end else begin
          bus.target <= '0;
          bus.hit    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Directed vector bench for pc_target_table: table lookups, writes, link stack and async reset.
module tb_pc_target_table;
  import pc_target_table_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pc_target_table_if bus ();

  pc_target_table dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          lookup;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    pc_t           wr_target;
    logic          call;
    logic          ret;
    pc_t           link_pc;
    logic          exp_valid;
    pc_t           exp_target;
    logic          exp_hit;
    logic          exp_empty;
    logic          exp_full;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t makeVec(input int lk, input int ad, input int we, input int wi,
                                   input int wt, input int ca, input int re, input int lp,
                                   input int ev, input int et, input int eh, input int ee,
                                   input int ef, input int eo);
    vec_t v;
    v.lookup     = lk[0];
    v.addr       = AW'(ad);
    v.wr_en      = we[0];
    v.wr_idx     = IW'(wi);
    v.wr_target  = pc_t'(wt);
    v.call       = ca[0];
    v.ret        = re[0];
    v.link_pc    = pc_t'(lp);
    v.exp_valid  = ev[0];
    v.exp_target = pc_t'(et);
    v.exp_hit    = eh[0];
    v.exp_empty  = ee[0];
    v.exp_full   = ef[0];
    v.exp_ovf    = eo[0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.lookup    = v.lookup;
    bus.addr      = v.addr;
    bus.wr_en     = v.wr_en;
    bus.wr_idx    = v.wr_idx;
    bus.wr_target = v.wr_target;
    bus.call      = v.call;
    bus.ret       = v.ret;
    bus.link_pc   = v.link_pc;
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " tgt_valid"},    32'(bus.tgt_valid),    32'(v.exp_valid));
    checkOutput({tag, " target"},       32'(bus.target),       32'(v.exp_target));
    checkOutput({tag, " hit"},          32'(bus.hit),          32'(v.exp_hit));
    checkOutput({tag, " ras_empty"},    32'(bus.ras_empty),    32'(v.exp_empty));
    checkOutput({tag, " ras_full"},     32'(bus.ras_full),     32'(v.exp_full));
    checkOutput({tag, " ras_overflow"}, 32'(bus.ras_overflow), 32'(v.exp_ovf));
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkAll(tag, v);
  endtask

  initial begin
    vec_t idle;
    idle = makeVec(0,0,0,0,0,0,0,0, 0,0,0,1,0,0);

    // lk ad we wi wt ca re lp | valid target hit empty full ovf
    vecs.push_back(makeVec(1, 3,0,0,  0,0,0, 0, 1, 53,1,1,0,0));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,0, 0, 0, 53,1,1,0,0));
    vecs.push_back(makeVec(1,20,0,0,  0,0,0, 0, 1,  0,0,1,0,0));
    vecs.push_back(makeVec(1,12,0,0,  0,0,0, 0, 1,  1,1,1,0,0));
    vecs.push_back(makeVec(1, 0,0,0,  0,0,0, 0, 1,  0,1,1,0,0));
    vecs.push_back(makeVec(1,15,0,0,  0,0,0, 0, 1,  1,1,1,0,0));
    vecs.push_back(makeVec(1,16,0,0,  0,0,0, 0, 1,  0,0,1,0,0));
    vecs.push_back(makeVec(1, 5,1,5,200,0,0, 0, 1,200,1,1,0,0));
    vecs.push_back(makeVec(1, 5,0,0,  0,0,0, 0, 1,200,1,1,0,0));
    vecs.push_back(makeVec(1, 6,1,7,300,0,0, 0, 1, 87,1,1,0,0));
    vecs.push_back(makeVec(1, 7,0,0,  0,0,0, 0, 1,300,1,1,0,0));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,0,10, 0,300,1,0,0,0));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,0,11, 0,300,1,0,0,0));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,0,12, 0,300,1,0,0,0));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,0,13, 0,300,1,0,1,0));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,0,14, 0,300,1,0,1,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1, 14,1,0,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1, 13,1,0,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1, 12,1,0,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1, 11,1,1,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1,  0,0,1,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,0,40, 0,  0,0,0,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,1,41, 1, 40,1,0,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1, 41,1,1,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,1,1,50, 1,  0,0,0,0,1));
    vecs.push_back(makeVec(1, 1,0,0,  0,0,1, 0, 1, 50,1,1,0,1));
    vecs.push_back(makeVec(1, 1,0,0,  0,0,1, 0, 1,  0,0,1,0,1));
    vecs.push_back(makeVec(1, 2,0,0,  0,1,0,60, 1, 30,1,0,0,1));
    vecs.push_back(makeVec(0, 0,0,0,  0,0,1, 0, 1, 60,1,1,0,1));

    rst_n = 1'b0;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", idle);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    $display("[TB] reset-in-flight sequence");
    runVec("rst_wr2",   makeVec(0,0,1,2,99,0,0,0, 0,60,1,1,0,1));
    runVec("rst_lk2",   makeVec(1,2,0,0, 0,0,0,0, 1,99,1,1,0,1));
    runVec("rst_push1", makeVec(0,0,0,0, 0,1,0,1, 0,99,1,0,0,1));
    runVec("rst_push2", makeVec(0,0,0,0, 0,1,0,2, 0,99,1,0,0,1));
    runVec("rst_req",   makeVec(1,3,0,0, 0,0,0,0, 1,53,1,0,0,1));
    applyStimulus(idle);
    #2 rst_n = 1'b0;
    #1;
    checkAll("rst_async", idle);
    @(negedge clk);
    rst_n = 1'b1;
    runVec("rst_after", idle);
    runVec("rst_lk2d",  makeVec(1,2,0,0, 0,0,0,0, 1,30,1,1,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
